// File: rtl/mode_state_machine_pkg.sv
// rtl/mode_state_machine_pkg.sv - mode codes and width shared by the mode state machine slice
package mode_state_machine_pkg;

  localparam int MODE_WIDTH = 3;

  typedef enum logic [MODE_WIDTH-1:0] {
    POWER_OFF   = 3'd0,
    STAND_MODE  = 3'd1,
    FIRST_MODE  = 3'd2,
    SECOND_MODE = 3'd3,
    THIRD_MODE  = 3'd4
  } mode_e;

  function automatic logic is_timed(input mode_e m);
    return (m == SECOND_MODE) || (m == THIRD_MODE);
  endfunction

endpackage

// File: rtl/mode_state_machine_second_tick_gen.sv
// rtl/mode_state_machine_second_tick_gen.sv - prescaler producing one tick per CLK_FREQ_HZ enabled cycles
module second_tick_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick ignores clear so the consumer can base its transition decision on it without a loop.
  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mode_state_machine.sv
// rtl/mode_state_machine.sv - owner of current_mode with timed hurricane/self-clean modes
// Optional feature macro: HURRICANE_ONCE_EN (hurricane allowed once per power cycle).
module mode_state_machine
  import mode_state_machine_pkg::*;
#(
  parameter int CLK_FREQ_HZ       = 100_000_000,
  parameter int SECOND_DURATION_S = 60,
  parameter int THIRD_DURATION_S  = 180
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  power_on,
  input  logic                  first_mode_toggle,
  input  logic                  second_mode_toggle,
  input  logic                  third_mode_toggle,
  input  logic                  standby_toggle,
  output logic [MODE_WIDTH-1:0] current_mode,
  output logic [7:0]            countdown_s,
  output logic                  mode_changed
);

  mode_e      mode_q, mode_d;
  logic [7:0] countdown_q, countdown_d;
  logic       mode_changed_q;
  logic       tick;
  logic       second_ok;

`ifdef HURRICANE_ONCE_EN
  logic hurricane_used_q, hurricane_used_d;
  assign second_ok = !hurricane_used_q;
`else
  assign second_ok = 1'b1;
`endif

  second_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(is_timed(mode_q)),
    .clear (mode_d != mode_q),
    .tick  (tick)
  );

  always_comb begin
    mode_d      = mode_q;
    countdown_d = countdown_q;
    if (!power_on) begin
      mode_d = POWER_OFF;
    end else begin
      unique case (mode_q)
        POWER_OFF: mode_d = STAND_MODE;
        STAND_MODE: begin
          if (first_mode_toggle)                   mode_d = FIRST_MODE;
          else if (second_mode_toggle && second_ok) mode_d = SECOND_MODE;
          else if (third_mode_toggle)              mode_d = THIRD_MODE;
        end
        FIRST_MODE: begin
          if (standby_toggle)                      mode_d = STAND_MODE;
          else if (second_mode_toggle && second_ok) mode_d = SECOND_MODE;
        end
        SECOND_MODE: begin
          if (standby_toggle)         mode_d = STAND_MODE;
          else if (first_mode_toggle) mode_d = FIRST_MODE;
          else if (tick) begin
            if (countdown_q == 8'd1) mode_d = FIRST_MODE;
            else                     countdown_d = countdown_q - 8'd1;
          end
        end
        THIRD_MODE: begin
          if (tick) begin
            if (countdown_q == 8'd1) mode_d = STAND_MODE;
            else                     countdown_d = countdown_q - 8'd1;
          end
        end
        default: mode_d = POWER_OFF;
      endcase
    end
    // Any mode change either loads a fresh duration or zeroes the countdown.
    if (mode_d != mode_q) begin
      if (mode_d == SECOND_MODE)     countdown_d = 8'(SECOND_DURATION_S);
      else if (mode_d == THIRD_MODE) countdown_d = 8'(THIRD_DURATION_S);
      else                           countdown_d = 8'd0;
    end
  end

`ifdef HURRICANE_ONCE_EN
  always_comb begin
    hurricane_used_d = hurricane_used_q;
    if (!power_on) begin
      hurricane_used_d = 1'b0;
    end else if ((mode_d == SECOND_MODE) && (mode_q != SECOND_MODE)) begin
      hurricane_used_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hurricane_used_q <= 1'b0;
    end else begin
      hurricane_used_q <= hurricane_used_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q         <= POWER_OFF;
      countdown_q    <= 8'd0;
      mode_changed_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      countdown_q    <= countdown_d;
      mode_changed_q <= (mode_d != mode_q);
    end
  end

  assign current_mode = mode_q;
  assign countdown_s  = countdown_q;
  assign mode_changed = mode_changed_q;

endmodule
